// File: rtl/systolic_seq_pkg.sv
// rtl/systolic_seq_pkg.sv - shared types and constants for the systolic array sequencer
// Contents: default geometry (P_N, P_DATA_WIDTH, P_K_MAX), FSM state enum,
// lane operand type, and the drain-length helper.
package systolic_seq_pkg;

  localparam int P_N          = 4;
  localparam int P_DATA_WIDTH = 8;
  localparam int P_K_MAX      = 16;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} seq_state_t;

  typedef logic [P_DATA_WIDTH-1:0] lane_t;

  // Cycles needed after the last read for the deepest skewed operand to cross the array.
  function automatic int DRAIN_CYCLES(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/systolic_seq_if.sv
// rtl/systolic_seq_if.sv - control, operand-memory and array-edge bundle of the sequencer
// master (sequencer): in  start, k_len, a_mem_data, b_mem_data
//                     out busy, done, acc_clr, mem_rd_en, mem_rd_addr,
//                         a_to_array, b_to_array, a_valid, b_valid
//                         (+ perf_cycles when SYS_SEQ_PERF_EN is defined)
// slave: the same signals seen from the buffers/array side.
interface systolic_seq_if #(
  parameter int N          = systolic_seq_pkg::P_N,
  parameter int DATA_WIDTH = systolic_seq_pkg::P_DATA_WIDTH,
  parameter int ADDR_WIDTH = $clog2(systolic_seq_pkg::P_K_MAX),
  parameter int KW         = $clog2(systolic_seq_pkg::P_K_MAX + 1)
);
  logic                    start;
  logic [KW-1:0]           k_len;
  logic                    busy;
  logic                    done;
  logic                    acc_clr;
  logic                    mem_rd_en;
  logic [ADDR_WIDTH-1:0]   mem_rd_addr;
  logic [N*DATA_WIDTH-1:0] a_mem_data;
  logic [N*DATA_WIDTH-1:0] b_mem_data;
  logic [N*DATA_WIDTH-1:0] a_to_array;
  logic [N*DATA_WIDTH-1:0] b_to_array;
  logic [N-1:0]            a_valid;
  logic [N-1:0]            b_valid;
`ifdef SYS_SEQ_PERF_EN
  logic [15:0]             perf_cycles;
`endif

  modport master (
    input  start, k_len, a_mem_data, b_mem_data,
    output busy, done, acc_clr, mem_rd_en, mem_rd_addr,
    output a_to_array, b_to_array, a_valid, b_valid
`ifdef SYS_SEQ_PERF_EN
    , output perf_cycles
`endif
  );

  modport slave (
    output start, k_len, a_mem_data, b_mem_data,
    input  busy, done, acc_clr, mem_rd_en, mem_rd_addr,
    input  a_to_array, b_to_array, a_valid, b_valid
`ifdef SYS_SEQ_PERF_EN
    , input perf_cycles
`endif
  );

endinterface

// File: rtl/systolic_seq_lane_skew.sv
// rtl/systolic_seq_lane_skew.sv - lane_skew: delays one {valid, data} edge lane by DEPTH cycles
// Ports: clk, rst (async, active-high), i_valid/i_data in, o_valid/o_data out.
// o_data is forced to zero whenever o_valid is low.
module lane_skew #(
  parameter int DEPTH = 0,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);
  logic             w_valid;
  logic [WIDTH-1:0] w_data;

  generate
    if (DEPTH == 0) begin : g_wire
      // Lane 0 has no skew; clock and reset are intentionally unused here.
      logic w_unused;
      assign w_unused = clk ^ rst;
      assign w_valid  = i_valid;
      assign w_data   = i_data;
    end else begin : g_shift
      logic [WIDTH:0] r_pipe [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < DEPTH; k++) r_pipe[k] <= '0;
        end else begin
          r_pipe[0] <= {i_valid, i_data};
          for (int k = 1; k < DEPTH; k++) r_pipe[k] <= r_pipe[k-1];
        end
      end

      assign {w_valid, w_data} = r_pipe[DEPTH-1];
    end
  endgenerate

  assign o_valid = w_valid;
  assign o_data  = w_valid ? w_data : '0;

endmodule

// File: rtl/systolic_seq_ctrl.sv
// rtl/systolic_seq_ctrl.sv - sequencer feeding skewed operands into an N x N MAC array
// Ports: clk, rst (async, active-high), bus (systolic_seq_if.master).
// Flow: IDLE -> CLEAR (acc_clr) -> FEED (k_len reads) -> DRAIN (2N cycles) -> DONE (done pulse).
// Optional: SYS_SEQ_PERF_EN adds bus.perf_cycles, a saturating count of busy cycles per op.
module systolic_seq_ctrl
  import systolic_seq_pkg::*;
#(
  parameter int N          = P_N,
  parameter int DATA_WIDTH = P_DATA_WIDTH,
  parameter int K_MAX      = P_K_MAX,
  parameter int ADDR_WIDTH = $clog2(K_MAX),
  parameter int KW         = $clog2(K_MAX + 1)
) (
  input logic            clk,
  input logic            rst,
  systolic_seq_if.master bus
);
  localparam int DRW = $clog2(DRAIN_CYCLES(N) + 1);

  seq_state_t              r_state, w_next;
  logic [KW-1:0]           r_k_len;
  logic [KW-1:0]           r_cnt;
  logic [KW-1:0]           w_k_clamp;
  logic [DRW-1:0]          r_drain;
  logic                    r_dv;
  logic                    w_last_rd;
  logic [N-1:0]            w_a_valid, w_b_valid;
  logic [N*DATA_WIDTH-1:0] w_a_data, w_b_data;

  assign w_k_clamp = (bus.k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len;
  // Only evaluated in FEED, where r_k_len >= 1.
  assign w_last_rd = (r_cnt == r_k_len - KW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    bus.busy        = 1'b1;
    bus.done        = 1'b0;
    bus.acc_clr     = 1'b0;
    bus.mem_rd_en   = 1'b0;
    bus.mem_rd_addr = '0;
    case (r_state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) w_next = CLEAR;
      end
      CLEAR: begin
        bus.acc_clr = 1'b1;
        w_next      = (r_k_len != '0) ? FEED : DONE;
      end
      FEED: begin
        bus.mem_rd_en   = 1'b1;
        bus.mem_rd_addr = r_cnt[ADDR_WIDTH-1:0];
        if (w_last_rd) w_next = DRAIN;
      end
      DRAIN: begin
        if (r_drain == '0) w_next = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k_len <= '0;
      r_cnt   <= '0;
      r_drain <= '0;
      r_dv    <= 1'b0;
    end else begin
      // Memory returns data one cycle after the read strobe.
      r_dv <= (r_state == FEED);
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_k_len <= w_k_clamp;
            r_cnt   <= '0;
          end
        end
        FEED: begin
          r_cnt <= r_cnt + KW'(1);
          if (w_last_rd) r_drain <= DRW'(DRAIN_CYCLES(N) - 1);
        end
        DRAIN: r_drain <= r_drain - DRW'(1);
        default: ;
      endcase
    end
  end

  // Lane i is delayed by i so row i / column j operands meet diagonally at PE(i,j).
  for (genvar i = 0; i < N; i++) begin : g_lane
    lane_skew #(.DEPTH(i), .WIDTH(DATA_WIDTH)) u_a_skew (
      .clk     (clk),
      .rst     (rst),
      .i_valid (r_dv),
      .i_data  (bus.a_mem_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .o_valid (w_a_valid[i]),
      .o_data  (w_a_data[i*DATA_WIDTH +: DATA_WIDTH])
    );
    lane_skew #(.DEPTH(i), .WIDTH(DATA_WIDTH)) u_b_skew (
      .clk     (clk),
      .rst     (rst),
      .i_valid (r_dv),
      .i_data  (bus.b_mem_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .o_valid (w_b_valid[i]),
      .o_data  (w_b_data[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign bus.a_valid    = w_a_valid;
  assign bus.b_valid    = w_b_valid;
  assign bus.a_to_array = w_a_data;
  assign bus.b_to_array = w_b_data;

`ifdef SYS_SEQ_PERF_EN
  logic [15:0] r_perf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf <= '0;
    end else if (r_state == IDLE && bus.start) begin
      r_perf <= '0;
    end else if (r_state != IDLE && r_perf != 16'hFFFF) begin
      r_perf <= r_perf + 16'd1;
    end
  end

  assign bus.perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb/tb_systolic_seq_ctrl.sv - randomized self-checking bench for systolic_seq_ctrl
module tb_systolic_seq_ctrl;
  import systolic_seq_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int K_MAX = 16;
  localparam int AW    = 4;
  localparam int KW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  systolic_seq_if #(.N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .KW(KW)) sif ();

  systolic_seq_ctrl #(.N(N), .DATA_WIDTH(DW), .K_MAX(K_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.master)
  );

  int checks = 0;
  int errors = 0;

  logic [N*DW-1:0] amem [K_MAX];
  logic [N*DW-1:0] bmem [K_MAX];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Operand memories: one-cycle read latency, junk on the bus when not reading.
  always @(posedge clk) begin
    if (sif.mem_rd_en) begin
      sif.a_mem_data <= amem[sif.mem_rd_addr];
      sif.b_mem_data <= bmem[sif.mem_rd_addr];
    end else begin
      sif.a_mem_data <= (N*DW)'($urandom());
      sif.b_mem_data <= (N*DW)'($urandom());
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // History of edge outputs, used to replay a behavioural MAC array.
  logic [N-1:0]    h_av [4096];
  logic [N-1:0]    h_bv [4096];
  logic [N*DW-1:0] h_ad [4096];
  logic [N*DW-1:0] h_bd [4096];

  // Reference model: one op in flight, described by its start cycle and depth.
  bit op_valid = 0;
  int op_s, op_k, op_d;

  always @(negedge clk) begin : cmp
    logic            e_busy, e_done, e_clr, e_rd;
    logic [AW-1:0]   e_addr;
    logic [N-1:0]    e_av, e_bv;
    logic [N*DW-1:0] e_ad, e_bd;
    int c, r, idx, kl;
    e_busy = 0; e_done = 0; e_clr = 0; e_rd = 0; e_addr = '0;
    e_av = '0; e_bv = '0; e_ad = '0; e_bd = '0;
    c = int'(cyc);
    if (rst) begin
      op_valid = 0;
    end else begin
      if ((!op_valid || c > op_d) && sif.start) begin
        kl       = int'(sif.k_len);
        op_valid = 1;
        op_s     = c;
        op_k     = (kl > K_MAX) ? K_MAX : kl;
        op_d     = (op_k == 0) ? c + 2 : c + 2 + op_k + DRAIN_CYCLES(N);
      end
      if (op_valid && c <= op_d) begin
        r      = c - op_s;
        e_busy = (r >= 1);
        e_clr  = (r == 1);
        e_done = (c == op_d);
        e_rd   = (r >= 2) && (r < 2 + op_k);
        if (e_rd) e_addr = AW'(r - 2);
        for (int i = 0; i < N; i++) begin
          idx = r - 3 - i;
          if (idx >= 0 && idx < op_k) begin
            e_av[i] = 1'b1;
            e_bv[i] = 1'b1;
            e_ad[i*DW +: DW] = amem[idx][i*DW +: DW];
            e_bd[i*DW +: DW] = bmem[idx][i*DW +: DW];
          end
        end
      end
    end
    chk("busy",        64'(sif.busy),        64'(e_busy));
    chk("done",        64'(sif.done),        64'(e_done));
    chk("acc_clr",     64'(sif.acc_clr),     64'(e_clr));
    chk("mem_rd_en",   64'(sif.mem_rd_en),   64'(e_rd));
    chk("mem_rd_addr", 64'(sif.mem_rd_addr), 64'(e_addr));
    chk("a_valid",     64'(sif.a_valid),     64'(e_av));
    chk("b_valid",     64'(sif.b_valid),     64'(e_bv));
    chk("a_to_array",  64'(sif.a_to_array),  64'(e_ad));
    chk("b_to_array",  64'(sif.b_to_array),  64'(e_bd));
    h_av[cyc % 4096] = sif.a_valid;
    h_bv[cyc % 4096] = sif.b_valid;
    h_ad[cyc % 4096] = sif.a_to_array;
    h_bd[cyc % 4096] = sif.b_to_array;
  end

  task automatic randomize_mem();
    for (int k = 0; k < K_MAX; k++) begin
      amem[k] = (N*DW)'($urandom());
      bmem[k] = (N*DW)'($urandom());
    end
  endtask

  // Pulses start for one cycle and follows the op until done (bounded).
  task automatic run_op(input int kl, output int rel, output int rds, output int last,
                        output int s_cyc);
    bit seen;
    seen = 0; rel = 0; rds = 0; last = -1;
    @(posedge clk); #2;
    sif.start = 1'b1;
    sif.k_len = KW'(kl);
    @(negedge clk);
    s_cyc = int'(cyc);
    @(posedge clk); #2;
    sif.start = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      rel++;
      if (sif.mem_rd_en) begin
        rds++;
        last = int'(sif.mem_rd_addr);
      end
      if (sif.done) begin
        seen = 1;
        break;
      end
    end
    chk("op_done_seen", 64'(seen), 64'd1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int rel, rds, last, s, acc, ek;
    lane_t av, bv;
    sif.start = 1'b0;
    sif.k_len = '0;
    sif.a_mem_data = '0;
    sif.b_mem_data = '0;
    randomize_mem();

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("reset_busy", 64'(sif.busy), 64'd0);
    chk("reset_a_valid", 64'(sif.a_valid), 64'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;

    // Basic op, k_len = 3
    run_op(3, rel, rds, last, s);
    chk("t1_done_cycle", 64'(rel), 64'd13);
    chk("t1_reads", 64'(rds), 64'd3);
    chk("t1_last_addr", 64'(last), 64'd2);

    // Identity A, B rows 1..16; replayed MAC array must give C = B
    for (int k = 0; k < K_MAX; k++) begin
      amem[k] = '0;
      for (int j = 0; j < N; j++) bmem[k][j*DW +: DW] = DW'(4*k + j + 1);
    end
    for (int k = 0; k < N; k++) amem[k][k*DW +: DW] = DW'(1);
    run_op(4, rel, rds, last, s);
    chk("t2_done_cycle", 64'(rel), 64'd14);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int t = s; t <= s + rel; t++) begin
          if (t - j >= s && t - i >= s &&
              h_av[(t-j) % 4096][i] && h_bv[(t-i) % 4096][j]) begin
            av = h_ad[(t-j) % 4096][i*DW +: DW];
            bv = h_bd[(t-i) % 4096][j*DW +: DW];
            acc += int'(av) * int'(bv);
          end
        end
        chk($sformatf("t2_c_%0d_%0d", i, j), 64'(acc), 64'(4*i + j + 1));
      end
    end

    // k_len = 0
    randomize_mem();
    run_op(0, rel, rds, last, s);
    chk("t3_done_cycle", 64'(rel), 64'd2);
    chk("t3_reads", 64'(rds), 64'd0);

    // k_len beyond K_MAX is clamped
    run_op(20, rel, rds, last, s);
    chk("t4_done_cycle", 64'(rel), 64'd26);
    chk("t4_reads", 64'(rds), 64'd16);
    chk("t4_last_addr", 64'(last), 64'd15);

    // start held high through the op and during DONE
    @(posedge clk); #2;
    sif.start = 1'b1;
    sif.k_len = KW'(2);
    @(negedge clk);
    rel = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      rel++;
      if (sif.done) break;
    end
    chk("t5_done_cycle", 64'(rel), 64'd12);
    @(negedge clk);
    chk("t5_idle_after_done", 64'(sif.busy), 64'd0);
    @(posedge clk); #2 sif.start = 1'b0;
    @(negedge clk);
    chk("t5_restart_clr", 64'(sif.acc_clr), 64'd1);
    rel = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      rel++;
      if (sif.done) break;
    end
    chk("t5_second_done", 64'(rel), 64'd11);

    // Reset in the middle of FEED
    @(posedge clk); #2;
    sif.start = 1'b1;
    sif.k_len = KW'(8);
    @(posedge clk); #2 sif.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("t6_rd_addr_before_rst", 64'(sif.mem_rd_addr), 64'd2);
    rst = 1'b1;
    #1;
    chk("t6_busy_in_rst", 64'(sif.busy), 64'd0);
    chk("t6_rd_en_in_rst", 64'(sif.mem_rd_en), 64'd0);
    chk("t6_a_valid_in_rst", 64'(sif.a_valid), 64'd0);
    chk("t6_a_data_in_rst", 64'(sif.a_to_array), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    run_op(5, rel, rds, last, s);
    chk("t6_done_after_rst", 64'(rel), 64'd15);

    // Randomized ops
    for (int it = 0; it < 25; it++) begin
      randomize_mem();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      ek = int'($urandom_range(0, 20));
      run_op(ek, rel, rds, last, s);
      if (ek > K_MAX) ek = K_MAX;
      chk("rand_done_cycle", 64'(rel), 64'((ek == 0) ? 2 : 2 + ek + 2*N));
      chk("rand_reads", 64'(rds), 64'(ek));
    end

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
